pkt_field_extractor: RTL and testbench

- Upstream stage of myNodeInfo.
- Accepts a received packet as a stream of 16-bit words over a valid/ready handshake and decodes the header packet type.
- Checks packet length against the type, extracts the type-specific fields into shadow registers, then commits them to its outputs with a one-cycle en_MNI pulse.
- Malformed and unknown-type packets are dropped and counted; no pulse is produced for them.

---
 rtl/pkt_field_extractor.sv | 205 ++++++++++++++++++++
 tb/tb_pkt_field_extractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_field_extractor.sv
// Decodes a packet arriving as a valid/ready word stream, shadows its
// type-specific fields and commits them to myNodeInfo with a one-cycle en_MNI strobe.
module pkt_field_extractor #(
  parameter int WORD_WIDTH     = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_WIDTH-1:0]     in_data,
  input  logic                      in_last,
  output logic                      en_MNI,
  output logic [2:0]                fPktType,
  output logic [WORD_WIDTH-1:0]     hops,
  output logic [WORD_WIDTH-1:0]     energy,
  output logic [WORD_WIDTH-1:0]     e_threshold,
  output logic [WORD_WIDTH-1:0]     destinationID,
  output logic [WORD_WIDTH-1:0]     timeslot,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, FIELDS, DISCARD, EMIT} state_e;

  localparam logic [2:0] T_HB   = 3'b000;
  localparam logic [2:0] T_CHE  = 3'b001;
  localparam logic [2:0] T_INV  = 3'b010;
  localparam logic [2:0] T_CHTS = 3'b100;
  localparam logic [2:0] T_DATA = 3'b101;

  state_e                  state_q, state_d;
  logic [2:0]              type_q, type_d;
  logic [1:0]              idx_q, idx_d;
  logic [WORD_WIDTH-1:0]   sh_hops_q, sh_hops_d;
  logic [WORD_WIDTH-1:0]   sh_energy_q, sh_energy_d;
  logic [WORD_WIDTH-1:0]   sh_eth_q, sh_eth_d;
  logic [WORD_WIDTH-1:0]   sh_dest_q, sh_dest_d;
  logic [WORD_WIDTH-1:0]   sh_ts_q, sh_ts_d;

  logic [2:0]              fpkt_type_q;
  logic [WORD_WIDTH-1:0]   hops_q, energy_q, eth_q, dest_q, ts_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  logic xfer;
  logic commit;
  logic drop_inc;

  function automatic logic type_known(input logic [2:0] t);
    return (t == T_HB) || (t == T_CHE) || (t == T_INV) || (t == T_CHTS) || (t == T_DATA);
  endfunction

  // Index of the final field word (header excluded) for each known type
  function automatic logic [1:0] last_idx(input logic [2:0] t);
    case (t)
      T_HB, T_CHTS: return 2'd2;
      T_DATA:       return 2'd1;
      default:      return 2'd0;
    endcase
  endfunction

  assign in_ready = (state_q != EMIT);
  assign en_MNI   = (state_q == EMIT);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    idx_d       = idx_q;
    sh_hops_d   = sh_hops_q;
    sh_energy_d = sh_energy_q;
    sh_eth_d    = sh_eth_q;
    sh_dest_d   = sh_dest_q;
    sh_ts_d     = sh_ts_q;
    commit      = 1'b0;
    drop_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          type_d = in_data[2:0];
          idx_d  = 2'd0;
          if (in_last) begin
            drop_inc = 1'b1;
          end else if (type_known(in_data[2:0])) begin
            state_d = FIELDS;
          end else begin
            state_d = DISCARD;
          end
        end
      end
      FIELDS: begin
        if (xfer) begin
          case (type_q)
            T_HB: begin
              case (idx_q)
                2'd0:    sh_hops_d   = in_data;
                2'd1:    sh_energy_d = in_data;
                default: sh_eth_d    = in_data;
              endcase
            end
            T_CHTS: begin
              case (idx_q)
                2'd0:    sh_dest_d = in_data;
                2'd1:    sh_hops_d = in_data;
                default: sh_ts_d   = in_data;
              endcase
            end
            T_DATA: begin
              if (idx_q == 2'd0) sh_dest_d = in_data;
              else               sh_hops_d = in_data;
            end
            default: sh_dest_d = in_data;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == last_idx(type_q)) begin
            if (in_last) begin
              state_d = EMIT;
              commit  = 1'b1;
            end else begin
              state_d = DISCARD;
            end
          end else if (in_last) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DISCARD: begin
        if (xfer && in_last) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      type_q      <= 3'b000;
      idx_q       <= 2'd0;
      sh_hops_q   <= '0;
      sh_energy_q <= '0;
      sh_eth_q    <= '0;
      sh_dest_q   <= '0;
      sh_ts_q     <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      idx_q       <= idx_d;
      sh_hops_q   <= sh_hops_d;
      sh_energy_q <= sh_energy_d;
      sh_eth_q    <= sh_eth_d;
      sh_dest_q   <= sh_dest_d;
      sh_ts_q     <= sh_ts_d;
    end
  end

  // Outputs load from the next-state shadows so the final word is visible during en_MNI
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fpkt_type_q <= 3'b111;
      hops_q      <= '0;
      energy_q    <= '0;
      eth_q       <= '0;
      dest_q      <= '0;
      ts_q        <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (commit) begin
        fpkt_type_q <= type_q;
        case (type_q)
          T_HB: begin
            hops_q   <= sh_hops_d;
            energy_q <= sh_energy_d;
            eth_q    <= sh_eth_d;
          end
          T_CHTS: begin
            dest_q <= sh_dest_d;
            hops_q <= sh_hops_d;
            ts_q   <= sh_ts_d;
          end
          T_DATA: begin
            dest_q <= sh_dest_d;
            hops_q <= sh_hops_d;
          end
          default: dest_q <= sh_dest_d;
        endcase
      end
      if (drop_inc && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign fPktType      = fpkt_type_q;
  assign hops          = hops_q;
  assign energy        = energy_q;
  assign e_threshold   = eth_q;
  assign destinationID = dest_q;
  assign timeslot      = ts_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pkt_field_extractor.sv
// Directed bench for pkt_field_extractor: packet decode, drops, saturation and async reset.
module tb_pkt_field_extractor;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        en_MNI;
  logic [2:0]  fPktType;
  logic [15:0] hops, energy, e_threshold, destinationID, timeslot;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int pulse_base;

  pkt_field_extractor #(.WORD_WIDTH(16), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .en_MNI(en_MNI), .fPktType(fPktType), .hops(hops), .energy(energy),
    .e_threshold(e_threshold), .destinationID(destinationID), .timeslot(timeslot),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (en_MNI) pulse_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one word and hold it until an edge where in_ready is high accepts it
  task automatic xfer(input logic [15:0] d, input logic l);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout: in_ready stuck low for word 0x%0h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_last  = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    nrst     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #12;
    check_val("rst_ready", in_ready, 1);
    check_val("rst_en", en_MNI, 0);
    check_val("rst_type", fPktType, 3'b111);
    check_val("rst_hops", hops, 0);
    check_val("rst_drop", drop_cnt, 0);
    @(negedge clk);
    nrst = 1'b1;
    idle_cycles(2);

    // 1: HB with a stall in the middle
    pulse_base = pulse_cnt;
    xfer(16'h0000, 1'b0);
    xfer(16'h0001, 1'b0);
    idle_cycles(3);
    xfer(16'h8000, 1'b0);
    xfer(16'h3333, 1'b1);
    check_val("s1_en", en_MNI, 1);
    check_val("s1_ready", in_ready, 0);
    check_val("s1_type", fPktType, 3'b000);
    check_val("s1_hops", hops, 16'h0001);
    check_val("s1_energy", energy, 16'h8000);
    check_val("s1_eth", e_threshold, 16'h3333);
    check_val("s1_dest", destinationID, 16'h0000);
    check_val("s1_drop", drop_cnt, 0);
    idle_cycles(1);
    check_val("s1_en_off", en_MNI, 0);
    check_val("s1_ready_back", in_ready, 1);
    check_val("s1_pulses", pulse_cnt - pulse_base, 1);

    // 2: CHE updates only type and destination
    xfer(16'h0001, 1'b0);
    xfer(16'h000C, 1'b1);
    check_val("s2_en", en_MNI, 1);
    check_val("s2_type", fPktType, 3'b001);
    check_val("s2_dest", destinationID, 16'h000C);
    check_val("s2_hops", hops, 16'h0001);
    check_val("s2_energy", energy, 16'h8000);
    idle_cycles(1);

    // 3: short CHTimeslot dropped, then Data
    pulse_base = pulse_cnt;
    xfer(16'h0004, 1'b0);
    xfer(16'h0015, 1'b0);
    xfer(16'h0002, 1'b1);
    check_val("s3_short_en", en_MNI, 0);
    check_val("s3_short_drop", drop_cnt, 1);
    check_val("s3_short_type", fPktType, 3'b001);
    check_val("s3_short_dest", destinationID, 16'h000C);
    check_val("s3_short_hops", hops, 16'h0001);
    xfer(16'h0005, 1'b0);
    xfer(16'h000E, 1'b0);
    xfer(16'h0003, 1'b1);
    check_val("s3_data_en", en_MNI, 1);
    check_val("s3_data_type", fPktType, 3'b101);
    check_val("s3_data_dest", destinationID, 16'h000E);
    check_val("s3_data_hops", hops, 16'h0003);
    check_val("s3_data_ts", timeslot, 16'h0000);
    check_val("s3_pulses", pulse_cnt - pulse_base + 1, 1);

    // 4: unknown type discarded, INV back-to-back
    idle_cycles(1);
    pulse_base = pulse_cnt;
    xfer(16'h0007, 1'b0);
    xfer(16'h1111, 1'b0);
    xfer(16'h2222, 1'b0);
    xfer(16'h4444, 1'b1);
    check_val("s4_unk_drop", drop_cnt, 2);
    check_val("s4_unk_en", en_MNI, 0);
    xfer(16'h0002, 1'b0);
    xfer(16'h0020, 1'b1);
    check_val("s4_inv_en", en_MNI, 1);
    check_val("s4_inv_type", fPktType, 3'b010);
    check_val("s4_inv_dest", destinationID, 16'h0020);
    check_val("s4_inv_hops", hops, 16'h0003);
    check_val("s4_inv_drop", drop_cnt, 2);

    // 5: too-long CHE, then drop counter saturation
    idle_cycles(1);
    pulse_base = pulse_cnt;
    xfer(16'h0001, 1'b0);
    xfer(16'h0044, 1'b0);
    xfer(16'h0055, 1'b1);
    check_val("s5_long_drop", drop_cnt, 3);
    check_val("s5_long_dest", destinationID, 16'h0020);
    check_val("s5_long_type", fPktType, 3'b010);
    for (int i = 0; i < 252; i++) xfer(16'h0000, 1'b1);
    check_val("s5_drop_at_max", drop_cnt, 8'hFF);
    for (int i = 0; i < 48; i++) xfer(16'h0000, 1'b1);
    check_val("s5_drop_sat", drop_cnt, 8'hFF);
    check_val("s5_pulses", pulse_cnt - pulse_base, 0);
    check_val("s5_hops", hops, 16'h0003);

    // 6: asynchronous reset mid-packet
    xfer(16'h0000, 1'b0);
    xfer(16'h0009, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    check_val("s6_rst_type", fPktType, 3'b111);
    check_val("s6_rst_hops", hops, 0);
    check_val("s6_rst_dest", destinationID, 0);
    check_val("s6_rst_drop", drop_cnt, 0);
    check_val("s6_rst_ready", in_ready, 1);
    @(negedge clk);
    nrst = 1'b1;
    idle_cycles(1);
    pulse_base = pulse_cnt;
    xfer(16'h0001, 1'b0);
    xfer(16'h000C, 1'b1);
    check_val("s6_che_en", en_MNI, 1);
    check_val("s6_che_type", fPktType, 3'b001);
    check_val("s6_che_dest", destinationID, 16'h000C);
    check_val("s6_che_hops", hops, 16'h0000);
    check_val("s6_che_drop", drop_cnt, 0);
    idle_cycles(3);
    check_val("s6_pulses", pulse_cnt - pulse_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
